id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly upstream of the EX-stage forwarding unit.
- Captures decoded operands, register specifiers (Rs/Rt/Rd) and control bits every cycle, and drives the ID_EX_Rs / ID_EX_Rt that the forwarding unit consumes.
- Contains load-use hazard detection: on a hazard it inserts a bubble and stalls PC and IF/ID.
- Also handles branch flush and an external pipeline hold.

Parameters:
- DATA_WIDTH, 32, width of operand and immediate datapaths.
- REG_ADDR_WIDTH, 5, register specifier width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Hold  in  1  global freeze (memory wait); register retains contents
- Flush  in  1  branch/jump taken; ID instruction squashed
- ID_Valid  in  1  instruction in ID is real (not a bubble)
- ID_ReadData1, ID_ReadData2  in  DATA_WIDTH  register file read data
- ID_SignExtImm  in  DATA_WIDTH  sign-extended immediate
- ID_Rs, ID_Rt, ID_Rd  in  REG_ADDR_WIDTH  specifiers
- ID_UsesRt  in  1  instruction reads Rt as a source (R-type, sw, beq)
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegDst, ID_ALUSrc  in  1  control bits
- ID_ALUOp  in  2  ALU operation class
- ID_EX_Valid  out  1  registered valid
- ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm  out  DATA_WIDTH
- ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  out  REG_ADDR_WIDTH
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_RegDst, ID_EX_ALUSrc  out  1
- ID_EX_ALUOp  out  2
- PCWrite  out  1  0 = hold PC
- IF_ID_Write  out  1  0 = hold IF/ID register
- LoadUseStallCount  out  32  bubble counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including data, specifiers, control, Valid and the counter.
- Hazard, combinational: LoadUse = ID_EX_Valid & ID_EX_MemRead & (ID_EX_Rt != 0) & ID_Valid & ((ID_EX_Rt == ID_Rs) | (ID_UsesRt & (ID_EX_Rt == ID_Rt))) & !Flush & !Hold.
- PCWrite = IF_ID_Write = !LoadUse. These do not depend on Hold; the hold is distributed separately.
- Register update at each rising edge, in this priority order:
  1. Hold=1: all registers keep their values.
  2. Flush=1: bubble is loaded (Valid=0, all seven control fields=0; data and specifiers loaded from ID).
  3. LoadUse=1: bubble as for Flush. The ID instruction stays in IF/ID and is re-presented next cycle.
  4. Otherwise: all fields load from ID inputs, and ID_EX_Valid=ID_Valid. If ID_Valid=0, the control fields are forced to 0.
- Latency: one cycle from ID inputs to ID_EX outputs.
- A load-use stall lasts exactly one cycle. After the bubble, ID_EX_MemRead=0, so LoadUse deasserts and the dependent instruction advances. The forwarding unit then supplies the value from MEM/WB.
- Back-to-back loads into the same register each cause one bubble. No double stall occurs.
- Hold with LoadUse pending: there is no stall and no bubble during the hold. The hazard re-evaluates when Hold drops.
- Reset mid-stall: all outputs go to 0 immediately; PCWrite=IF_ID_Write=1 after reset.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined: a 32-bit counter increments on every clock edge where LoadUse=1. It wraps from 0xFFFFFFFF to 0, is unaffected by Flush, is frozen by Hold (which gates LoadUse off) and cleared by reset. It drives LoadUseStallCount.
- Undefined: there is no counter logic and LoadUseStallCount is tied to 0.

Decomposition:
- Shared package mips_pipe_pkg:
  - the ALUOp encoding constants;
  - REG_ADDR_WIDTH and DATA_WIDTH defaults;
  - a packed ex_ctrl_t struct (RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, ALUOp) and the BUBBLE_CTRL constant (all 0).
- One natural sub-module, load_use_detect: purely combinational, producing LoadUse. The register bank stays in the top level.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle while the register holds data -> all outputs 0 immediately; PCWrite=1, IF_ID_Write=1 once released.
- Passthrough: ID add $3,$1,$2 (Rs=1, Rt=2, Rd=3, RegWrite=1, ALUOp=2'b10) -> same values on ID_EX_* one cycle later, Valid=1.
- Load-use:
  - ID_EX holds lw $5 (MemRead=1, Rt=5); ID has add $6,$5,$7.
  - Expect PCWrite=IF_ID_Write=0 that cycle, then a bubble registered (controls 0, Valid=0).
  - Next cycle: add is registered with Rs=5 and PCWrite=1.
- No false stall:
  - lw $0 followed by add $1,$0,$2 -> no stall.
  - lw $5 followed by addi $5,$4,1 (ID_UsesRt=0, Rs=4) -> no stall.
- Flush/Hold priority:
  - Flush=1 with LoadUse conditions present -> bubble registered, PCWrite=1.
  - Hold=1 for 3 cycles -> outputs unchanged; Hold wins over a simultaneous Flush.
- Counter (STALL_CNT_EN): 4 load-use events -> LoadUseStallCount=4; preset near wrap, one stall at 0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stages: datapath width defaults,
// ALUOp class encodings and the EX-stage control bundle.
package mips_pipe_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;

  // ALU operation classes handed from decode to the EX-stage ALU control
  localparam logic [1:0] ALUOP_ADD    = 2'b00;  // lw/sw address arithmetic
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // beq compare (subtract)
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // use funct field
  localparam logic [1:0] ALUOP_IMM    = 2'b11;  // immediate-class ops

  // Control bits carried from ID into EX and beyond
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
  } ex_ctrl_t;

  // A bubble must not write registers or memory, so every control bit is 0
  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the load sitting in ID/EX writes a
// register that the instruction in ID is about to read. Register 0 never
// causes a hazard, and a hold or flush in progress suppresses the stall.
module load_use_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rt,
  input  logic                      flush,
  input  logic                      hold,
  output logic                      load_use
);

  logic rs_match;
  logic rt_match;

  // Compare the load destination against the sources the ID instruction reads
  always_comb begin
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt && (ex_rt == id_rt);
    load_use = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid &&
               (rs_match || rt_match) && !flush && !hold;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// global hold. Optional macro STALL_CNT_EN adds a 32-bit counter of load-use
// stall cycles on LoadUseStallCount; without it that output is tied to 0.
module id_ex_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      Hold,
  input  logic                      Flush,
  input  logic                      ID_Valid,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
  input  logic [DATA_WIDTH-1:0]     ID_SignExtImm,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rs,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rt,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rd,
  input  logic                      ID_UsesRt,
  input  logic                      ID_RegWrite,
  input  logic                      ID_MemRead,
  input  logic                      ID_MemWrite,
  input  logic                      ID_MemtoReg,
  input  logic                      ID_RegDst,
  input  logic                      ID_ALUSrc,
  input  logic [1:0]                ID_ALUOp,
  output logic                      ID_EX_Valid,
  output logic [DATA_WIDTH-1:0]     ID_EX_ReadData1,
  output logic [DATA_WIDTH-1:0]     ID_EX_ReadData2,
  output logic [DATA_WIDTH-1:0]     ID_EX_SignExtImm,
  output logic [REG_ADDR_WIDTH-1:0] ID_EX_Rs,
  output logic [REG_ADDR_WIDTH-1:0] ID_EX_Rt,
  output logic [REG_ADDR_WIDTH-1:0] ID_EX_Rd,
  output logic                      ID_EX_RegWrite,
  output logic                      ID_EX_MemRead,
  output logic                      ID_EX_MemWrite,
  output logic                      ID_EX_MemtoReg,
  output logic                      ID_EX_RegDst,
  output logic                      ID_EX_ALUSrc,
  output logic [1:0]                ID_EX_ALUOp,
  output logic                      PCWrite,
  output logic                      IF_ID_Write,
  output logic [31:0]               LoadUseStallCount
);

  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0]     rd2_q, rd2_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
  logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  ex_ctrl_t                  ctrl_q, ctrl_d;
  ex_ctrl_t                  id_ctrl;
  logic                      load_use;

  load_use_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (rt_q),
    .id_valid    (ID_Valid),
    .id_rs       (ID_Rs),
    .id_rt       (ID_Rt),
    .id_uses_rt  (ID_UsesRt),
    .flush       (Flush),
    .hold        (Hold),
    .load_use    (load_use)
  );

  // Bundle the decoded control bits so bubbles can zero them in one step
  always_comb begin
    id_ctrl            = BUBBLE_CTRL;
    id_ctrl.reg_write  = ID_RegWrite;
    id_ctrl.mem_read   = ID_MemRead;
    id_ctrl.mem_write  = ID_MemWrite;
    id_ctrl.mem_to_reg = ID_MemtoReg;
    id_ctrl.reg_dst    = ID_RegDst;
    id_ctrl.alu_src    = ID_ALUSrc;
    id_ctrl.alu_op     = ID_ALUOp;
  end

  // Next register contents: hold keeps, flush/load-use loads a bubble, else ID
  always_comb begin
    valid_d = valid_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (!Hold) begin
      rd1_d = ID_ReadData1;
      rd2_d = ID_ReadData2;
      imm_d = ID_SignExtImm;
      rs_d  = ID_Rs;
      rt_d  = ID_Rt;
      rd_d  = ID_Rd;
      if (Flush || load_use) begin
        valid_d = 1'b0;
        ctrl_d  = BUBBLE_CTRL;
      end else begin
        valid_d = ID_Valid;
        ctrl_d  = ID_Valid ? id_ctrl : BUBBLE_CTRL;
      end
    end
  end

  // Pipeline register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= BUBBLE_CTRL;
    end else begin
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count stall cycles; Hold already masks load_use so the count freezes too
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign LoadUseStallCount = stall_cnt_q;
`else
  assign LoadUseStallCount = '0;
`endif

  assign PCWrite          = !load_use;
  assign IF_ID_Write      = !load_use;
  assign ID_EX_Valid      = valid_q;
  assign ID_EX_ReadData1  = rd1_q;
  assign ID_EX_ReadData2  = rd2_q;
  assign ID_EX_SignExtImm = imm_q;
  assign ID_EX_Rs         = rs_q;
  assign ID_EX_Rt         = rt_q;
  assign ID_EX_Rd         = rd_q;
  assign ID_EX_RegWrite   = ctrl_q.reg_write;
  assign ID_EX_MemRead    = ctrl_q.mem_read;
  assign ID_EX_MemWrite   = ctrl_q.mem_write;
  assign ID_EX_MemtoReg   = ctrl_q.mem_to_reg;
  assign ID_EX_RegDst     = ctrl_q.reg_dst;
  assign ID_EX_ALUSrc     = ctrl_q.alu_src;
  assign ID_EX_ALUOp      = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, flush, id_valid, id_uses_rt;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [7:0]  id_ctrl;

  logic        ex_valid;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_reg_dst, ex_alu_src;
  logic [1:0]  ex_alu_op;
  logic        pc_write, if_id_write;
  logic [31:0] stall_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model of what ID/EX should hold; ctrl packs
  // {RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, ALUOp[1:0]}
  logic        m_valid;
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [7:0]  m_ctrl;
  logic [31:0] m_cnt;

  localparam logic [7:0] CTRL_ADD  = 8'b1000_1010;
  localparam logic [7:0] CTRL_LW   = 8'b1101_0100;
  localparam logic [7:0] CTRL_ADDI = 8'b1000_0100;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Hold              (hold),
    .Flush             (flush),
    .ID_Valid          (id_valid),
    .ID_ReadData1      (id_rd1),
    .ID_ReadData2      (id_rd2),
    .ID_SignExtImm     (id_imm),
    .ID_Rs             (id_rs),
    .ID_Rt             (id_rt),
    .ID_Rd             (id_rd),
    .ID_UsesRt         (id_uses_rt),
    .ID_RegWrite       (id_ctrl[7]),
    .ID_MemRead        (id_ctrl[6]),
    .ID_MemWrite       (id_ctrl[5]),
    .ID_MemtoReg       (id_ctrl[4]),
    .ID_RegDst         (id_ctrl[3]),
    .ID_ALUSrc         (id_ctrl[2]),
    .ID_ALUOp          (id_ctrl[1:0]),
    .ID_EX_Valid       (ex_valid),
    .ID_EX_ReadData1   (ex_rd1),
    .ID_EX_ReadData2   (ex_rd2),
    .ID_EX_SignExtImm  (ex_imm),
    .ID_EX_Rs          (ex_rs),
    .ID_EX_Rt          (ex_rt),
    .ID_EX_Rd          (ex_rd),
    .ID_EX_RegWrite    (ex_reg_write),
    .ID_EX_MemRead     (ex_mem_read),
    .ID_EX_MemWrite    (ex_mem_write),
    .ID_EX_MemtoReg    (ex_mem_to_reg),
    .ID_EX_RegDst      (ex_reg_dst),
    .ID_EX_ALUSrc      (ex_alu_src),
    .ID_EX_ALUOp       (ex_alu_op),
    .PCWrite           (pc_write),
    .IF_ID_Write       (if_id_write),
    .LoadUseStallCount (stall_count)
  );

  // Hazard rule evaluated on the model's notion of the ID/EX contents
  function automatic logic modelLoadUse();
    return m_valid && m_ctrl[6] && (m_rt != 5'd0) && id_valid &&
           ((m_rt == id_rs) || (id_uses_rt && (m_rt == id_rt))) &&
           !flush && !hold;
  endfunction

  function automatic logic [31:0] expectedCount();
`ifdef STALL_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic clearModel();
    m_valid = 1'b0;
    m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
    m_ctrl = '0;
    m_cnt = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, " valid"}, {31'd0, ex_valid}, {31'd0, m_valid});
    checkOutput({tag, " rd1"}, ex_rd1, m_rd1);
    checkOutput({tag, " rd2"}, ex_rd2, m_rd2);
    checkOutput({tag, " imm"}, ex_imm, m_imm);
    checkOutput({tag, " spec"}, {17'd0, ex_rs, ex_rt, ex_rd},
                {17'd0, m_rs, m_rt, m_rd});
    checkOutput({tag, " ctrl"},
                {24'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                 ex_reg_dst, ex_alu_src, ex_alu_op},
                {24'd0, m_ctrl});
    checkOutput({tag, " count"}, stall_count, expectedCount());
  endtask

  task automatic driveInputs(input logic h, input logic f, input logic v,
                             input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic u,
                             input logic [7:0] c);
    hold = h; flush = f; id_valid = v;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = u; id_ctrl = c;
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
  endtask

  // One cycle: drive at negedge, check stall outputs, clock, check registers
  task automatic applyStimulus(input string tag, input logic h, input logic f,
                               input logic v, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic u, input logic [7:0] c);
    logic lu;
    @(negedge clk);
    driveInputs(h, f, v, rs, rt, rd, u, c);
    #1;
    lu = modelLoadUse();
    checkOutput({tag, " PCWrite"}, {31'd0, pc_write}, {31'd0, !lu});
    checkOutput({tag, " IF_ID_Write"}, {31'd0, if_id_write}, {31'd0, !lu});
    @(posedge clk);
    if (!hold) begin
      m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      if (flush || lu) begin
        m_valid = 1'b0;
        m_ctrl  = 8'd0;
      end else begin
        m_valid = id_valid;
        m_ctrl  = id_valid ? id_ctrl : 8'd0;
      end
      if (lu) m_cnt = m_cnt + 32'd1;
    end
    #1;
    checkRegs(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    driveInputs(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 8'd0);
    clearModel();
    #1;
    checkRegs("reset_init");
    checkOutput("reset_init PCWrite", {31'd0, pc_write}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Passthrough: add $3,$1,$2
    applyStimulus("add", 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, CTRL_ADD);
    checkOutput("add rs", {27'd0, ex_rs}, 32'd1);
    checkOutput("add rd", {27'd0, ex_rd}, 32'd3);
    checkOutput("add aluop", {30'd0, ex_alu_op}, 32'd2);
    checkOutput("add valid", {31'd0, ex_valid}, 32'd1);

    // Load-use: lw $5 then add $6,$5,$7 -> one bubble, then add advances
    applyStimulus("lw5", 1'b0, 1'b0, 1'b1, 5'd4, 5'd5, 5'd0, 1'b0, CTRL_LW);
    applyStimulus("lu_stall", 1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, CTRL_ADD);
    checkOutput("lu bubble valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu bubble memread", {31'd0, ex_mem_read}, 32'd0);
    applyStimulus("lu_retry", 1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, CTRL_ADD);
    checkOutput("lu retry rs", {27'd0, ex_rs}, 32'd5);
    checkOutput("lu retry valid", {31'd0, ex_valid}, 32'd1);

    // No false stall on $0 or on an unused Rt
    applyStimulus("lw0", 1'b0, 1'b0, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, CTRL_LW);
    applyStimulus("add_r0", 1'b0, 1'b0, 1'b1, 5'd0, 5'd2, 5'd1, 1'b1, CTRL_ADD);
    checkOutput("r0 no stall valid", {31'd0, ex_valid}, 32'd1);
    applyStimulus("lw5b", 1'b0, 1'b0, 1'b1, 5'd4, 5'd5, 5'd0, 1'b0, CTRL_LW);
    applyStimulus("addi", 1'b0, 1'b0, 1'b1, 5'd4, 5'd5, 5'd5, 1'b0, CTRL_ADDI);
    checkOutput("addi no stall valid", {31'd0, ex_valid}, 32'd1);

    // Back-to-back dependent loads each produce exactly one bubble
    applyStimulus("lw6", 1'b0, 1'b0, 1'b1, 5'd1, 5'd6, 5'd0, 1'b0, CTRL_LW);
    applyStimulus("lw7_stall", 1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, CTRL_LW);
    applyStimulus("lw7_go", 1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, CTRL_LW);
    applyStimulus("dep_stall", 1'b0, 1'b0, 1'b1, 5'd6, 5'd3, 5'd2, 1'b1, CTRL_ADD);
    applyStimulus("dep_go", 1'b0, 1'b0, 1'b1, 5'd6, 5'd3, 5'd2, 1'b1, CTRL_ADD);

    // Flush beats a pending load-use: bubble, PC keeps moving
    applyStimulus("lw5c", 1'b0, 1'b0, 1'b1, 5'd4, 5'd5, 5'd0, 1'b0, CTRL_LW);
    applyStimulus("flush", 1'b0, 1'b1, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, CTRL_ADD);
    checkOutput("flush PCWrite", {31'd0, pc_write}, 32'd1);
    checkOutput("flush valid", {31'd0, ex_valid}, 32'd0);

    // Hold for three cycles over a pending hazard, one with Flush as well
    applyStimulus("lw5d", 1'b0, 1'b0, 1'b1, 5'd4, 5'd5, 5'd0, 1'b0, CTRL_LW);
    applyStimulus("hold1", 1'b1, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, CTRL_ADD);
    applyStimulus("hold2", 1'b1, 1'b1, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, CTRL_ADD);
    applyStimulus("hold3", 1'b1, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, CTRL_ADD);
    checkOutput("hold memread kept", {31'd0, ex_mem_read}, 32'd1);
    checkOutput("hold rt kept", {27'd0, ex_rt}, 32'd5);
    applyStimulus("unhold_stall", 1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, CTRL_ADD);
    checkOutput("unhold bubble", {31'd0, ex_valid}, 32'd0);

`ifdef STALL_CNT_EN
    checkOutput("count directed", stall_count, 32'd4);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    applyStimulus("wrap_lw", 1'b0, 1'b0, 1'b1, 5'd4, 5'd5, 5'd0, 1'b0, CTRL_LW);
    applyStimulus("wrap_stall", 1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, CTRL_ADD);
    checkOutput("count wrap", stall_count, 32'd0);
`endif

    // Reset in the middle of a stall clears everything at once
    applyStimulus("lw5e", 1'b0, 1'b0, 1'b1, 5'd4, 5'd5, 5'd0, 1'b0, CTRL_LW);
    @(negedge clk);
    driveInputs(1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, CTRL_ADD);
    #1;
    checkOutput("pre-reset PCWrite", {31'd0, pc_write}, 32'd0);
    rst_n = 1'b0;
    clearModel();
    #1;
    checkRegs("midstall_reset");
    checkOutput("reset PCWrite", {31'd0, pc_write}, 32'd1);
    checkOutput("reset IF_ID_Write", {31'd0, if_id_write}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset PCWrite", {31'd0, pc_write}, 32'd1);

    // Randomized traffic with small specifier range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [7:0] c;
      c = 8'($urandom);
      applyStimulus("random",
                    1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 9) != 0),
                    5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)),
                    c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
